// File: rtl/reverse_rotor0_diff_if.sv
// Letter stream bundle for the rotor-0 return path.
// master drives the letter and position, slave returns the mapped letter.
interface reverse_rotor0_diff_if;
  logic       in_valid;
  logic [4:0] data_in;
  logic [4:0] position;
  logic [4:0] data_out;
  logic [4:0] index;
  logic       out_valid;

  modport master (
    output in_valid, data_in, position,
    input  data_out, index, out_valid
  );

  modport slave (
    input  in_valid, data_in, position,
    output data_out, index, out_valid
  );
endinterface

// File: rtl/reverse_rotor0_diff.sv
// Enigma rotor I, reverse direction, for rotor slot 0.
// Wiring is held as per-contact offsets; one registered stage.
module reverse_rotor0_diff (
  input  logic                 clk,
  input  logic                 rst_n,
  reverse_rotor0_diff_if.slave bus
);

  function automatic logic [4:0] rdiff(input logic [4:0] i);
    logic [4:0] r;
    r = 5'd0;
    case (i)
      5'd0:  r = 5'd20;
      5'd1:  r = 5'd21;
      5'd2:  r = 5'd22;
      5'd3:  r = 5'd3;
      5'd4:  r = 5'd22;
      5'd5:  r = 5'd24;
      5'd6:  r = 5'd25;
      5'd7:  r = 5'd8;
      5'd8:  r = 5'd13;
      5'd9:  r = 5'd16;
      5'd10: r = 5'd17;
      5'd11: r = 5'd19;
      5'd12: r = 5'd16;
      5'd13: r = 5'd23;
      5'd14: r = 5'd24;
      5'd15: r = 5'd4;
      5'd16: r = 5'd17;
      5'd17: r = 5'd6;
      5'd18: r = 5'd0;
      5'd19: r = 5'd18;
      5'd20: r = 5'd23;
      5'd21: r = 5'd13;
      5'd22: r = 5'd17;
      5'd23: r = 5'd19;
      5'd24: r = 5'd16;
      5'd25: r = 5'd10;
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  logic [4:0] d;
  logic [4:0] p;
  logic [6:0] sum;
  logic [4:0] idx;
  logic [6:0] t;
  logic [6:0] t1;
  logic [4:0] out;

  always_comb begin
    d   = (bus.data_in  >= 5'd26) ? bus.data_in  - 5'd26 : bus.data_in;
    p   = (bus.position >= 5'd26) ? bus.position - 5'd26 : bus.position;
    sum = {2'b00, d} + {2'b00, p};
    idx = (sum >= 7'd26) ? 5'(sum - 7'd26) : sum[4:0];
    // +26 keeps the subtraction of p non-negative; result is below 78
    t   = {2'b00, idx} + {2'b00, rdiff(idx)} + 7'd26 - {2'b00, p};
    t1  = (t >= 7'd52) ? t - 7'd52 : t;
    out = (t1 >= 7'd26) ? 5'(t1 - 7'd26) : t1[4:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.data_out  <= 5'd0;
      bus.index     <= 5'd0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.data_out <= out;
        bus.index    <= idx;
      end
    end
  end

endmodule

// File: tb/tb_reverse_rotor0_diff.sv
// Bench for reverse_rotor0_diff against an absolute-wiring model.
// Directed, sweep, reset and random phases.
module tb_reverse_rotor0_diff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_out = 0;
  int   m_idx = 0;
  string wiring = "UWYGADFPVZBECKMTHXSLRINQOJ";

  always #5 clk = ~clk;

  reverse_rotor0_diff_if bus ();

  reverse_rotor0_diff dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic int red(input int v);
    return (v >= 26) ? v - 26 : v;
  endfunction

  function automatic int ref_idx(input int d, input int p);
    return (red(d) + red(p)) % 26;
  endfunction

  function automatic int ref_out(input int d, input int p);
    int i;
    int letter;
    i = ref_idx(d, p);
    letter = int'(wiring[i]) - int'("A");
    return (letter - red(p) + 26) % 26;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input int d, input int p);
    bus.in_valid = v;
    bus.data_in  = 5'(d);
    bus.position = 5'(p);
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input int d, input int p,
                     input int e_idx, input int e_out);
    step(1'b1, d, p);
    chk({tag, "_idx"}, int'(bus.index), e_idx);
    chk({tag, "_out"}, int'(bus.data_out), e_out);
    chk({tag, "_ov"}, int'(bus.out_valid), 1);
    chk({tag, "_mdl"}, ref_out(d, p), e_out);
  endtask

  initial begin
    logic [25:0] seen;
    int cnt;
    int o;
    int d;
    int p;
    logic v;

    bus.in_valid = 1'b0;
    bus.data_in  = 5'd0;
    bus.position = 5'd0;
    #2;

    rst_n = 1'b0;
    step(1'b1, 7, 0);
    step(1'b1, 7, 0);
    chk("rst_out", int'(bus.data_out), 0);
    chk("rst_idx", int'(bus.index), 0);
    chk("rst_ov", int'(bus.out_valid), 0);
    rst_n = 1'b1;
    step(1'b0, 7, 0);
    chk("post_rst_out", int'(bus.data_out), 0);
    chk("post_rst_idx", int'(bus.index), 0);
    chk("post_rst_ov", int'(bus.out_valid), 0);

    vec("v0", 4, 0, 4, 0);
    vec("v1", 9, 1, 10, 0);
    vec("v2", 12, 6, 18, 12);
    vec("wrap", 25, 1, 0, 19);
    vec("oor", 30, 0, 4, 0);

    step(1'b0, 17, 3);
    chk("hold_out", int'(bus.data_out), 0);
    chk("hold_idx", int'(bus.index), 4);
    chk("hold_ov", int'(bus.out_valid), 0);

    for (int pp = 0; pp < 26; pp++) begin
      seen = '0;
      for (int dd = 0; dd < 26; dd++) begin
        if (pp == 13 && dd == 10) begin
          rst_n = 1'b0;
          step(1'b1, dd, pp);
          chk("mid_rst_out", int'(bus.data_out), 0);
          chk("mid_rst_idx", int'(bus.index), 0);
          chk("mid_rst_ov", int'(bus.out_valid), 0);
          rst_n = 1'b1;
        end
        step(1'b1, dd, pp);
        o = int'(bus.data_out);
        chk("sw_out", o, ref_out(dd, pp));
        chk("sw_idx", int'(bus.index), ref_idx(dd, pp));
        chk("sw_ov", int'(bus.out_valid), 1);
        if (o < 26) seen[o] = 1'b1;
      end
      cnt = $countones(seen);
      chk("sw_distinct", cnt, 26);
    end

    m_out = int'(bus.data_out);
    m_idx = ref_idx(25, 25);
    for (int k = 0; k < 400; k++) begin
      v = 1'($urandom_range(0, 1));
      d = int'($urandom_range(0, 31));
      p = int'($urandom_range(0, 31));
      step(v, d, p);
      if (v) begin
        m_out = ref_out(d, p);
        m_idx = ref_idx(d, p);
      end
      chk("rnd_out", int'(bus.data_out), m_out);
      chk("rnd_idx", int'(bus.index), m_idx);
      chk("rnd_ov", int'(bus.out_valid), int'(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
